// File: rtl/rvm_operand_fetch.sv
// rvm_operand_fetch: multi-cycle operand staging in front of the 32-bit add/sub unit.
// Fetches up to two source registers through one synchronous RF read port, substitutes
// PC/immediate operands where selected, and presents a registered lhs/rhs/op triple.
// Optional macro RVM_OPFETCH_BYPASS_EN: forward matching writeback data into operands.
module rvm_operand_fetch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [RF_AW-1:0] req_rs1,
  input  logic [RF_AW-1:0] req_rs2,
  input  logic             req_lhs_sel,
  input  logic             req_rhs_sel,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic [2:0]       req_op,
  output logic             rf_ren,
  output logic [RF_AW-1:0] rf_addr,
  input  logic [XLEN-1:0]  rf_rdata,
  input  logic             wb_en,
  input  logic [RF_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_lhs,
  output logic [XLEN-1:0]  out_rhs,
  output logic [2:0]       out_op
);

  localparam logic [2:0] RVM_ARITH_NOP = 3'd0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD1   = 3'd1;
  localparam logic [2:0] ST_RD2   = 3'd2;
  localparam logic [2:0] ST_CAP2  = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [RF_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic             need1_q, need1_d, need2_q, need2_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  lhs_q, lhs_d, rhs_q, rhs_d;

  // Value to capture for each source: register read data, or a matching writeback.
  logic             hit1, hit2;
  logic [XLEN-1:0]  cap1, cap2;

`ifdef RVM_OPFETCH_BYPASS_EN
  // Writeback forwarding; register 0 is never forwarded.
  always_comb begin
    hit1 = wb_en && (wb_addr == rs1_q) && (wb_addr != '0);
    hit2 = wb_en && (wb_addr == rs2_q) && (wb_addr != '0);
    cap1 = hit1 ? wb_data : rf_rdata;
    cap2 = hit2 ? wb_data : rf_rdata;
  end
`else
  logic wb_unused;
  assign wb_unused = ^{wb_en, wb_addr, wb_data};

  // No forwarding: captured values always come from the register file.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    cap1 = rf_rdata;
    cap2 = rf_rdata;
  end
`endif

  assign req_ready = (state_q == ST_IDLE) && !flush && !reset;
  assign out_valid = (state_q == ST_ISSUE);
  assign out_op    = out_valid ? op_q : RVM_ARITH_NOP;
  assign out_lhs   = lhs_q;
  assign out_rhs   = rhs_q;

  // Next-state, operand capture and register-file read control.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    need1_d = need1_q;
    need2_d = need2_q;
    op_d    = op_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    rf_ren  = 1'b0;
    rf_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          op_d    = req_op;
          need1_d = !req_lhs_sel && (req_rs1 != '0);
          need2_d = !req_rhs_sel && (req_rs2 != '0);
          // Register operands are overwritten later; x0 stays zero.
          lhs_d   = req_lhs_sel ? req_pc : '0;
          rhs_d   = req_rhs_sel ? req_imm : '0;
          if (need1_d) begin
            state_d = ST_RD1;
          end else if (need2_d) begin
            state_d = ST_RD2;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_RD1: begin
        rf_ren  = 1'b1;
        rf_addr = rs1_q;
        state_d = ST_RD2;
      end
      ST_RD2: begin
        // RD2 is only reached from RD1 when rs1 was read.
        if (need1_q) begin
          lhs_d = cap1;
        end
        if (need2_q) begin
          rf_ren  = 1'b1;
          rf_addr = rs2_q;
          state_d = ST_CAP2;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_CAP2: begin
        rhs_d   = cap2;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (need1_q && hit1) begin
          lhs_d = cap1;
        end
        if (need2_q && hit2) begin
          rhs_d = cap2;
        end
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      need1_q <= 1'b0;
      need2_q <= 1'b0;
      op_q    <= RVM_ARITH_NOP;
      lhs_q   <= '0;
      rhs_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      need1_q <= need1_d;
      need2_q <= need2_d;
      op_q    <= op_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
    end
  end

endmodule

// File: tb/tb_rvm_operand_fetch.sv
// Testbench for rvm_operand_fetch: directed scenarios plus randomized requests, with a
// queue-based scoreboard and an independent monitor process.
`timescale 1ns/1ps
module tb_rvm_operand_fetch;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;

  logic             clk = 1'b0;
  logic             reset, flush, req_valid, req_ready;
  logic [RF_AW-1:0] req_rs1, req_rs2;
  logic             req_lhs_sel, req_rhs_sel;
  logic [XLEN-1:0]  req_pc, req_imm;
  logic [2:0]       req_op;
  logic             rf_ren;
  logic [RF_AW-1:0] rf_addr;
  logic [XLEN-1:0]  rf_rdata = '0;
  logic             wb_en;
  logic [RF_AW-1:0] wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_lhs, out_rhs;
  logic [2:0]       out_op;

  always #5 clk = ~clk;

  rvm_operand_fetch #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_lhs_sel(req_lhs_sel), .req_rhs_sel(req_rhs_sel),
    .req_pc(req_pc), .req_imm(req_imm), .req_op(req_op),
    .rf_ren(rf_ren), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lhs(out_lhs), .out_rhs(out_rhs), .out_op(out_op)
  );

  // Register file model with one-cycle synchronous read.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) if (rf_ren) rf_rdata <= rf[rf_addr];

  typedef struct {
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [2:0]      op;
    int              lat;
    int              acc_cyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [RF_AW-1:0] rd_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 2;   // 0 random, 1 held low, 2 held high
  bit abort_ok = 0;
  bit active = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_ready driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (rdy_mode == 2);
    end
  end

  // Monitor: RF read order, output triple against scoreboard, NOP when idle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_ren) begin
        check("rf_ren_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check("rf_addr", 32'(rf_addr), 32'(rd_q.pop_front()));
      end
      if (out_valid) begin
        if (!active) begin
          check("out_valid_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            active = 1;
            check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
          end
        end
        if (active) begin
          check("out_lhs", out_lhs, cur.lhs);
          check("out_rhs", out_rhs, cur.rhs);
          check("out_op", 32'(out_op), 32'(cur.op));
          check("req_ready_in_issue", 32'(req_ready), 0);
          if (out_ready) active = 0;
        end
      end else begin
        check("out_op_nop_idle", 32'(out_op), 32'(OP_NOP));
        if (active) begin
          check("out_valid_held", 32'(abort_ok), 1);
          active = 0;
        end
      end
    end
  end

  // Issue one request; the reference model computes expected operands and latency.
  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic ls,
                      input logic rs, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [2:0] op, input bit expect_out);
    exp_t e;
    int t;
    bit n1, n2;
    int nreads;
    @(posedge clk);
    #1;
    req_rs1 = rs1; req_rs2 = rs2; req_lhs_sel = ls; req_rhs_sel = rs;
    req_pc = pc; req_imm = imm; req_op = op; req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    n1 = !ls && rs1 != 0;
    n2 = !rs && rs2 != 0;
    nreads = int'(n1) + int'(n2);
    e.lhs = ls ? pc : (rs1 == 0 ? 32'h0 : rf[rs1]);
    e.rhs = rs ? imm : (rs2 == 0 ? 32'h0 : rf[rs2]);
`ifdef RVM_OPFETCH_BYPASS_EN
    if (wb_en && wb_addr != 0 && n1 && wb_addr == rs1) e.lhs = wb_data;
    if (wb_en && wb_addr != 0 && n2 && wb_addr == rs2) e.rhs = wb_data;
`endif
    e.op = op;
    e.lat = (nreads == 0) ? 1 : nreads + 2;
    e.acc_cyc = cyc;
    if (n1) rd_q.push_back(rs1);
    if (n2) rd_q.push_back(rs2);
    if (expect_out) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("return_to_idle", 32'(req_ready), 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_rises", 32'(out_valid), 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_lhs_sel = 1'b0; req_rhs_sel = 1'b0;
    req_pc = '0; req_imm = '0; req_op = OP_NOP;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0; rf[3] = 32'd5; rf[4] = 32'd7; rf[6] = 32'd1; rf[9] = 32'h8000_0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_op", 32'(out_op), 32'(OP_NOP));
    check("rst_rf_ren", 32'(rf_ren), 0);
    check("rst_rf_addr", 32'(rf_addr), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_out_lhs", out_lhs, 0);
    check("rst_out_rhs", out_rhs, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Two register reads.
    send(5'd3, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0, OP_ADD, 1);
    wait_idle();
    // PC + immediate, no reads.
    send(5'd7, 5'd8, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFC, OP_ADD, 1);
    wait_idle();
    // x0 on the left, single read on the right.
    send(5'd0, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, OP_SUB, 1);
    wait_idle();

    // Stall in ISSUE for five cycles, then release.
    rdy_mode = 1;
    send(5'd3, 5'd0, 1'b0, 1'b1, 32'h0, 32'h1234, OP_SUB, 1);
    wait_valid();
    repeat (5) @(negedge clk);
    check("stall_valid_held", 32'(out_valid), 1);
    rdy_mode = 2;
    wait_idle();
    check("released_valid_low", 32'(out_valid), 0);
    check("released_op_nop", 32'(out_op), 32'(OP_NOP));

    // Flush while in CAP2: nothing is issued.
    send(5'd3, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0, OP_ADD, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("cap2_rf_ren_low", 32'(rf_ren), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("idle_after_flush", 32'(req_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_valid_after_flush", 32'(out_valid), 0);
    end

    // Flush coinciding with a request: not accepted.
    @(posedge clk); #1;
    req_rs1 = 5'd3; req_rs2 = 5'd4; req_lhs_sel = 1'b0; req_rhs_sel = 1'b0;
    req_op = OP_ADD; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("req_ready_under_flush", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_read_after_flush", 32'(rf_ren), 0);
      check("no_valid_flush_req", 32'(out_valid), 0);
    end

    // Writeback to rs1 held across the whole transaction.
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
    send(5'd6, 5'd0, 1'b0, 1'b1, 32'h0, 32'h10, OP_ADD, 1);
    wait_idle();
    wb_en = 1'b0;

    // Reset while holding in ISSUE clears the operands.
    rdy_mode = 1;
    send(5'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 32'h5678, OP_ADD, 1);
    wait_valid();
    abort_ok = 1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_lhs", out_lhs, 0);
    check("midrst_rhs", out_rhs, 0);
    check("midrst_op", 32'(out_op), 32'(OP_NOP));
    @(negedge clk);
    abort_ok = 0;
    rdy_mode = 0;

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           $urandom, $urandom, 3'($urandom_range(1, 7)), 1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("reads_drained", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rvm_operand_fetch.md
Name: rvm_operand_fetch

Overview:
- Multi-cycle operand staging block that sits directly upstream of the 32-bit add/subtract unit in the ALU path.
- Accepts a decoded arithmetic request and fetches up to two source registers through the single synchronous read port of the register file.
- Selects immediate or PC operands instead of register values where requested.
- Presents a registered lhs/rhs/op triple to the adder with a valid/ready handshake.

Parameters:
XLEN, 32, operand width; the adder consumes 32.
RF_AW, 5, register file address width.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
flush  input  1  drop any in-flight request; return to IDLE
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_rs1  input  RF_AW  source register 1 address
req_rs2  input  RF_AW  source register 2 address
req_lhs_sel  input  1  0 = rs1, 1 = req_pc
req_rhs_sel  input  1  0 = rs2, 1 = req_imm
req_pc  input  XLEN  program counter operand
req_imm  input  XLEN  immediate operand
req_op  input  3  adder op code (RVM_ARITH_* encoding)
rf_ren  output  1  register file read enable
rf_addr  output  RF_AW  register file read address
rf_rdata  input  XLEN  read data, valid one cycle after rf_ren
wb_en  input  1  writeback write strobe (used only with bypass)
wb_addr  input  RF_AW  writeback address
wb_data  input  XLEN  writeback data
out_valid  output  1  lhs/rhs/op are valid
out_ready  input  1  consumer accepts
out_lhs  output  XLEN  left operand
out_rhs  output  XLEN  right operand
out_op  output  3  op; forced to RVM_ARITH_NOP whenever out_valid=0

Behaviour:
- Clock and reset: clk is the single clock. reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0; out_lhs=0; out_rhs=0; out_op=NOP; rf_ren=0; rf_addr=0; req_ready=0 during reset.
- Operand needs: need1 = (lhs_sel==0 && rs1!=0); need2 = (rhs_sel==0 && rs2!=0). A register operand with address 0 is 0, and the register file is not read for it.
- IDLE:
  - req_ready = !flush.
  - On req_valid&&req_ready: latch all req_* fields, then go to RD1 if need1, else RD2 if need2, else ISSUE.
  - Non-register operands are loaded at acceptance: lhs from pc when lhs_sel=1, zero when rs1=0; rhs from imm when rhs_sel=1, zero when rs2=0.
- RD1: rf_ren=1, rf_addr=rs1. Next state is RD2.
- RD2:
  - If RD2 was entered from RD1, capture rf_rdata into lhs.
  - If need2: rf_ren=1, rf_addr=rs2, next state CAP2; otherwise next state ISSUE.
- CAP2: capture rf_rdata into rhs. Next state is ISSUE.
- ISSUE:
  - out_valid=1, with out_lhs/out_rhs/out_op held stable.
  - On out_ready, return to IDLE. out_valid is not asserted in IDLE, so there is no back-to-back accept in the same cycle.
- Latency (accept edge to out_valid): 1 cycle with no register reads, 3 cycles with one read, 4 cycles with two reads.
- rf_ren is low in IDLE, CAP2 and ISSUE.
- flush:
  - In any state, the next state is IDLE, out_valid drops the following cycle, and captured operands are discarded.
  - flush has priority over out_ready and over acceptance.
- reset mid-operation has the same effect as flush, and additionally clears out_lhs and out_rhs.
- out_ready while out_valid=0 is ignored.
- Operand width matches the adder; no extension is applied.

Optional Feature:
- Macro: RVM_OPFETCH_BYPASS_EN.
- Defined:
  - In any cycle that captures rf_rdata (RD2 from RD1, or CAP2), if wb_en && wb_addr==source addr && wb_addr!=0, wb_data is captured instead of rf_rdata.
  - In ISSUE, a matching writeback to a register-sourced operand updates the held operand in place.
- Not defined: the wb_* ports are present but ignored; captured values always come from rf_rdata.

Test Plan:
- Reset, then rs1=3, rs2=4, both selects=0, op=ADD, RF[3]=5, RF[4]=7 -> rf_addr 3 then 4; out_valid 4 cycles after accept; lhs=5, rhs=7, op=ADD.
- lhs_sel=1, pc=0x100, rhs_sel=1, imm=0xFFFFFFFC -> no rf_ren; out_valid 1 cycle after accept; lhs=0x100, rhs=0xFFFFFFFC.
- rs1=0, rs2=9, RF[9]=0x80000000, op=SUB -> a single read of address 9; lhs=0, rhs=0x80000000; out_valid at +3.
- ISSUE with out_ready=0 for 5 cycles -> outputs stable, req_ready=0; out_ready=1 -> IDLE next cycle, and out_op=NOP once out_valid=0.
- flush asserted in CAP2 -> IDLE next cycle, out_valid never rises; flush in the same cycle as req_valid -> request not accepted.
- With RVM_OPFETCH_BYPASS_EN: rs1=6, RF[6]=1, wb_en with addr 6 and data 0x55 in the capture cycle -> lhs=0x55. Without the macro -> lhs=1.
